// File: rtl/rd_ptr_burst_ctrl.sv
// Read-side pointer and flag controller for the async FIFO with burst pops.
// Grants at most the words available, keeps binary and Gray read pointers,
// a registered fill level, almost-empty/empty flags and a sticky underflow.
module rd_ptr_burst_ctrl #(
    parameter int ADDRSIZE = 6,
    parameter int POPW     = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [POPW-1:0]     rpop,
    input  logic [ADDRSIZE:0]   rae_thresh,
    input  logic                rclr_err,
    output logic [POPW-1:0]     rgrant,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rbin,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic                runderflow
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          rempty_q, rempty_d;
    logic          ralmost_empty_q, ralmost_empty_d;
    logic          runderflow_q, runderflow_d;

    logic [PW-1:0]   wbin;
    logic [PW-1:0]   avail;
    logic [PW-1:0]   rpop_ext;
    logic [POPW-1:0] grant;
    logic            over_req;

    // Gray-to-binary of the synchronised write pointer: each bit is the XOR of itself and all higher Gray bits
    always_comb begin
        wbin = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            if (i == PW - 1) wbin[i] = rq2_wptr[i];
            else             wbin[i] = wbin[i+1] ^ rq2_wptr[i];
        end
    end

    // Grant clamp and next-state pointer/flag computation
    always_comb begin
        avail    = wbin - rbin_q;
        rpop_ext = PW'(rpop);
        over_req = (rpop_ext > avail);
        // On over-request avail < rpop < 2^POPW, so the truncation is lossless
        grant    = over_req ? avail[POPW-1:0] : rpop;

        rbin_d          = rbin_q + PW'(grant);
        rptr_d          = rbin_d ^ (rbin_d >> 1);
        rlevel_d        = wbin - rbin_d;
        rempty_d        = (rptr_d == rq2_wptr);
        ralmost_empty_d = (rlevel_d != '0) && (rlevel_d <= rae_thresh);

        runderflow_d = runderflow_q;
        if (over_req)      runderflow_d = 1'b1;
        else if (rclr_err) runderflow_d = 1'b0;
    end

    // State registers, asynchronously returned to the empty condition
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q          <= '0;
            rptr_q          <= '0;
            rlevel_q        <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b0;
            runderflow_q    <= 1'b0;
        end else begin
            rbin_q          <= rbin_d;
            rptr_q          <= rptr_d;
            rlevel_q        <= rlevel_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            runderflow_q    <= runderflow_d;
        end
    end

    assign rgrant        = grant;
    assign rbin          = rbin_q;
    assign raddr         = rbin_q[ADDRSIZE-1:0];
    assign rptr          = rptr_q;
    assign rlevel        = rlevel_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign runderflow    = runderflow_q;

endmodule

// File: tb/tb_rd_ptr_burst_ctrl.sv
// Directed bench for rd_ptr_burst_ctrl (ADDRSIZE=6, POPW=2).
module tb_rd_ptr_burst_ctrl;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic [6:0] rq2_wptr;
    logic [1:0] rpop;
    logic [6:0] rae_thresh;
    logic       rclr_err;
    logic [1:0] rgrant;
    logic [5:0] raddr;
    logic [6:0] rbin;
    logic [6:0] rptr;
    logic [6:0] rlevel;
    logic       rempty;
    logic       ralmost_empty;
    logic       runderflow;

    int total = 0;
    int bad   = 0;

    rd_ptr_burst_ctrl #(.ADDRSIZE(6), .POPW(2)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rq2_wptr(rq2_wptr), .rpop(rpop),
        .rae_thresh(rae_thresh), .rclr_err(rclr_err), .rgrant(rgrant),
        .raddr(raddr), .rbin(rbin), .rptr(rptr), .rlevel(rlevel),
        .rempty(rempty), .ralmost_empty(ralmost_empty), .runderflow(runderflow)
    );

    always #5 rclk = ~rclk;

    function automatic logic [6:0] gray(input logic [6:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    initial begin
        rrst_n = 1'b0; rq2_wptr = '0; rpop = '0; rae_thresh = 7'd2; rclr_err = 1'b0;
        #12;
        chk("rst_rempty", 32'(rempty), 1);
        chk("rst_rlevel", 32'(rlevel), 0);
        chk("rst_ae", 32'(ralmost_empty), 0);
        chk("rst_rbin", 32'(rbin), 0);
        chk("rst_rptr", 32'(rptr), 0);
        chk("rst_uf", 32'(runderflow), 0);
        tick();
        rrst_n = 1'b1;

        // five words written
        rq2_wptr = gray(7'd5);
        tick();
        chk("w5_level", 32'(rlevel), 5);
        chk("w5_empty", 32'(rempty), 0);
        chk("w5_ae", 32'(ralmost_empty), 0);

        // pop 3 -> full grant
        rpop = 2'd3;
        #1;
        chk("pop3_grant", 32'(rgrant), 3);
        chk("pop3_raddr_before", 32'(raddr), 0);
        tick();
        chk("pop3_rbin", 32'(rbin), 3);
        chk("pop3_rptr", 32'(rptr), 2);
        chk("pop3_level", 32'(rlevel), 2);
        chk("pop3_ae", 32'(ralmost_empty), 1);
        chk("pop3_empty", 32'(rempty), 0);
        chk("pop3_uf", 32'(runderflow), 0);

        // pop 3 with only 2 available -> partial grant, underflow
        #1;
        chk("part_grant", 32'(rgrant), 2);
        tick();
        chk("part_rbin", 32'(rbin), 5);
        chk("part_raddr", 32'(raddr), 5);
        chk("part_uf", 32'(runderflow), 1);
        chk("part_empty", 32'(rempty), 1);
        chk("part_level", 32'(rlevel), 0);
        chk("part_ae", 32'(ralmost_empty), 0);

        // clear with no request
        rpop = 2'd0; rclr_err = 1'b1;
        tick();
        chk("clr_uf", 32'(runderflow), 0);

        // clear together with over-request on empty: set wins
        rpop = 2'd1;
        #1;
        chk("empty_grant", 32'(rgrant), 0);
        tick();
        chk("setwin_uf", 32'(runderflow), 1);
        chk("empty_hold_rbin", 32'(rbin), 5);

        // sticky hold without clear
        rpop = 2'd0; rclr_err = 1'b0;
        tick();
        chk("sticky_uf", 32'(runderflow), 1);

        // asynchronous reset mid-stream, away from any clock edge
        #2;
        rrst_n = 1'b0;
        #1;
        chk("arst_rbin", 32'(rbin), 0);
        chk("arst_rempty", 32'(rempty), 1);
        chk("arst_uf", 32'(runderflow), 0);
        chk("arst_level", 32'(rlevel), 0);
        rq2_wptr = '0;
        tick();
        rrst_n = 1'b1;

        // advance read pointer to 126 with 42 pops of 3
        rq2_wptr = gray(7'd126);
        rpop = 2'd3;
        for (int i = 0; i < 42; i++) tick();
        rpop = 2'd0;
        chk("pre_wrap_rbin", 32'(rbin), 126);
        chk("pre_wrap_empty", 32'(rempty), 1);
        chk("pre_wrap_uf", 32'(runderflow), 0);

        // wrap: wbin=1, rbin=126 -> avail 3
        rq2_wptr = gray(7'd1);
        rpop = 2'd3;
        #1;
        chk("wrap_grant", 32'(rgrant), 3);
        tick();
        rpop = 2'd0;
        chk("wrap_rbin", 32'(rbin), 1);
        chk("wrap_rptr", 32'(rptr), 1);
        chk("wrap_raddr", 32'(raddr), 1);
        chk("wrap_empty", 32'(rempty), 1);
        chk("wrap_uf", 32'(runderflow), 0);

        // full FIFO: wbin = rbin + 64
        rae_thresh = 7'd5;
        rq2_wptr = gray(7'd65);
        tick();
        chk("full_level", 32'(rlevel), 64);
        chk("full_empty", 32'(rempty), 0);
        chk("full_ae", 32'(ralmost_empty), 0);

        rpop = 2'd1;
        for (int k = 1; k <= 64; k++) begin
            #1;
            chk("drain_grant", 32'(rgrant), 1);
            tick();
            chk("drain_level", 32'(rlevel), 32'(64 - k));
            chk("drain_ae", 32'(ralmost_empty), ((64 - k) != 0 && (64 - k) <= 5) ? 1 : 0);
            chk("drain_empty", 32'(rempty), (k == 64) ? 1 : 0);
        end
        rpop = 2'd0;
        chk("drain_rbin", 32'(rbin), 65);
        chk("drain_uf", 32'(runderflow), 0);

        // bursty writer: wptr jumps by 10
        rq2_wptr = gray(7'd75);
        #1;
        chk("jump_grant", 32'(rgrant), 0);
        tick();
        chk("jump_level", 32'(rlevel), 10);
        chk("jump_empty", 32'(rempty), 0);
        chk("jump_uf", 32'(runderflow), 0);
        chk("jump_rbin", 32'(rbin), 65);

        // threshold extremes
        rae_thresh = 7'd0;
        tick();
        chk("thr0_ae", 32'(ralmost_empty), 0);
        rae_thresh = 7'd64;
        tick();
        chk("thr64_ae", 32'(ralmost_empty), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
